seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Time-multiplexed scan driver for a 4-digit common-anode 7-segment display. It holds a 16-bit display word and cycles one nibble at a time through a binary_to_segment instance. It drives active-low anodes, segments and decimal point to the board pins. The block sits between the project datapath, which loads values, and the display pins.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz -> 1 kHz per digit, 250 Hz frame); legal range 2..2^20
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  1 = scan active; 0 = display dark
load  in  1  single-cycle strobe: capture value/dp_in into pending register
value  in  16  display word; nibble k drives digit k (digit 0 = rightmost)
dp_in  in  4  decimal point per digit, 1 = lit
blank_lz  in  1  1 = suppress leading zeros
an  out  4  anode enables, active-low, one-hot-low when lit
seg  out  7  segments, MSB = A, LSB = G, 0 = lit
dp  out  1  decimal point, active-low
frame_start  out  1  one-cycle pulse when the slot index wraps 3->0

Behaviour:
- Reset: an=4'b1111, seg=7'b1111111, dp=1, frame_start=0; prescaler=0, digit index=0, display/pending registers=0, pending flag=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler==REFRESH_DIV-1). On tick the digit index advances 0->1->2->3->0.
- frame_start pulses the cycle after a tick that wraps the index 3->0.
- Load: on load=1, pending_val<=value, pending_dp<=dp_in, pending flag<=1. A later load before commit overwrites the pending value (last wins).
- Commit (tear-free): on the 3->0 wrap tick, if the pending flag is set, display registers <= pending and the flag clears. If load and the commit tick coincide, the commit uses the pending contents from before the load; the new load stays pending with the flag set.
- Digit select: nibble = display_val[4k+3:4k]. The nibble feeds binary_to_segment and seg is registered from its output.
- Output latency: an/seg/dp are registered, one cycle after the index/prescaler state they reflect.
- Slot blanking: while prescaler < BLANK_CYCLES, an=4'b1111. Otherwise an = ~(1<<k).
- Leading-zero suppression (blank_lz=1): digit k>=1 is blank when nibbles 3..k are all zero; digit 0 is never blanked. A blank digit has an=4'b1111 for that slot and dp=1. A lit digit's dp comes from display_dp[k] (active-low out).
- enable=0: prescaler and index hold, an=4'b1111, seg=7'b1111111, dp=1. Load and pending behaviour continue. Re-enable resumes from the held state.
- Reset mid-frame: everything returns to reset values next cycle, including pending contents.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package/header: SEG_BLANK=7'b1111111, AN_OFF=4'b1111, NUM_DIGITS=4, default REFRESH_DIV/BLANK_CYCLES.
- One sub-module: binary_to_segment (4-bit -> 7-seg, MSB = A, active-low), instantiated once on the selected nibble.
- Prescaler, index, pending/commit and LZ logic stay in this module.

Test Plan:
(Bench uses REFRESH_DIV=4, BLANK_CYCLES=1.)
1. Reset, then idle: an=1111, seg=1111111, dp=1; after the first frame all four slots show digit 0. Digit 0 has an=1110 and seg=0000001; frame_start pulses every 16 cycles.
2. load value=16'hF0A1, dp_in=4'b0100, blank_lz=0: the display changes only after the next 3->0 wrap. Slot 3 then shows seg=0111000 (F) with an=0111, and slot 2 shows dp=0 with an=1011.
3. Load 16'h1234 then 16'h5678 within the same frame: only 5678 is displayed; 1234 never appears on the pins.
4. blank_lz=1, value=16'h0005: digits 3..1 have an=1111 in their slots and digit 0 has an=1110 showing 5. With value=16'h0000, only digit 0 is lit, showing 0.
5. load asserted exactly on the wrap tick with pending 16'h1111 and new 16'h2222: 1111 is displayed this frame and 2222 the following frame.
6. enable=0 mid-slot 2 for 10 cycles: outputs dark and the index holds at 2. After re-enable, slot 2 completes its remaining cycles. Then assert rst mid-frame: reset values appear on the next cycle.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: shared constants and the leading-zero test for the scan driver
package seg_scan_driver_pkg;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [3:0] AN_OFF = 4'b1111;
   localparam int NUM_DIGITS = 4;
   localparam int REFRESH_DIV_DEF = 100000;
   localparam int BLANK_CYCLES_DEF = 1000;
   // digit k>=1 is a leading zero when nibbles 3..k are all zero
   function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] k);
      return k != 2'd0 && (v >> {k, 2'b00}) == 16'd0;
   endfunction
endpackage

// File: rtl/seg_scan_driver_binary_to_segment.sv
// binary_to_segment: hex nibble to active-low 7-segment pattern, MSB = A
module binary_to_segment (
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'b1111111;
      case (nib)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0000100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         4'hF: seg = 7'b0111000;
         default: seg = 7'b1111111;
      endcase
   end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 4-digit common-anode 7-segment scan driver
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int REFRESH_DIV  = REFRESH_DIV_DEF,
   parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_start
);
   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   logic [PW-1:0] psc;
   logic [1:0]    idx;
   logic [15:0]   disp_val, pend_val;
   logic [3:0]    disp_dp, pend_dp;
   logic          pend, tick, wrap, dark;
   logic [3:0]    nib;
   logic [6:0]    seg_dec;
   assign tick = enable && psc == PW'(REFRESH_DIV - 1);
   assign wrap = tick && idx == 2'd3;
   assign nib  = disp_val[{idx, 2'b00} +: 4];
   assign dark = blank_lz && lz_blank(disp_val, idx);
   binary_to_segment u_dec (
      .nib(nib),
      .seg(seg_dec)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         psc         <= '0;
         idx         <= 2'd0;
         disp_val    <= 16'd0;
         disp_dp     <= 4'd0;
         pend_val    <= 16'd0;
         pend_dp     <= 4'd0;
         pend        <= 1'b0;
         an          <= AN_OFF;
         seg         <= SEG_BLANK;
         dp          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         if (enable) psc <= tick ? '0 : psc + 1'b1;
         if (tick) idx <= idx + 2'd1;
         frame_start <= wrap;
         // commit only at the frame wrap so a frame never mixes two words
         if (wrap && pend) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
            pend     <= 1'b0;
         end
         // a coincident load lands after the commit and stays pending
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
            pend     <= 1'b1;
         end
         an  <= (!enable || dark || psc < PW'(BLANK_CYCLES)) ? AN_OFF : ~(4'b0001 << idx);
         seg <= (!enable || dark) ? SEG_BLANK : seg_dec;
         dp  <= !enable || dark || !disp_dp[idx];
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized and directed checks against a frame-arithmetic reference model
module tb_seg_scan_driver;
   logic        clk = 1'b0;
   logic        rst, enable, load, blank_lz;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp, frame_start;
   int checks = 0;
   int errors = 0;
   // reference model: n counts enabled cycles; slot and position follow by division
   int          n;
   logic [15:0] m_disp, m_pend;
   logic [3:0]  m_ddp, m_pdp;
   bit          m_pf;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp, e_fs;
   logic [6:0]  font [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   always #5 clk = ~clk;
   seg_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp),
      .frame_start(frame_start)
   );
   task automatic model_step();
      int slot, pos;
      bit bl;
      logic [15:0] sh;
      if (rst) begin
         n = 0; m_disp = 0; m_pend = 0; m_ddp = 0; m_pdp = 0; m_pf = 0;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
      end else begin
         slot = (n / 4) % 4;
         pos  = n % 4;
         sh   = m_disp >> (4 * slot);
         bl   = blank_lz && slot > 0 && sh == 16'd0;
         if (!enable) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         end else begin
            e_an  = (pos < 1 || bl) ? 4'hF : ~(4'b0001 << slot);
            e_seg = bl ? 7'h7F : font[sh[3:0]];
            e_dp  = bl || !m_ddp[slot];
         end
         e_fs = enable && pos == 3 && slot == 3;
         if (e_fs && m_pf) begin
            m_disp = m_pend; m_ddp = m_pdp; m_pf = 0;
         end
         if (load) begin
            m_pend = value; m_pdp = dp_in; m_pf = 1;
         end
         if (enable) n++;
      end
   endtask
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask
   task automatic wait_pos(input int p);
      for (int i = 0; i < 32 && (n % 16) != p; i++) step();
   endtask
   function automatic string obs();
      return $sformatf("got an=%b seg=%b dp=%b fs=%b want an=%b seg=%b dp=%b fs=%b",
                       an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
   endfunction
   task automatic test_reset();
      int fs_cnt = 0;
      rst = 1; enable = 0; load = 0; value = 0; dp_in = 0; blank_lz = 0;
      step(); step();
      checks++;
      if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++; $display("FAIL reset_values got an=%b seg=%b dp=%b fs=%b", an, seg, dp, frame_start);
      end
      rst = 0; enable = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         fs_cnt += frame_start;
         checks++;
         if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
            errors++; $display("FAIL idle cyc %0d %s", i, obs());
         end
         if (an == 4'b1110) begin
            checks++;
            if (seg !== 7'b0000001) begin
               errors++; $display("FAIL idle_digit0 got seg=%b want 0000001", seg);
            end
         end
      end
      checks++;
      if (fs_cnt != 2) begin
         errors++; $display("FAIL frame_start_rate got %0d pulses want 2", fs_cnt);
      end
   endtask
   task automatic test_load_commit();
      bit saw_f = 0, saw_dp = 0;
      value = 16'hF0A1; dp_in = 4'b0100; blank_lz = 0; load = 1;
      step();
      load = 0;
      for (int i = 0; i < 48; i++) begin
         step();
         checks++;
         if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
            errors++; $display("FAIL load_commit cyc %0d %s", i, obs());
         end
         if (an == 4'b0111 && seg == 7'b0111000) saw_f = 1;
         if (an == 4'b1011 && dp == 1'b0) saw_dp = 1;
      end
      checks++;
      if (!(saw_f && saw_dp)) begin
         errors++; $display("FAIL load_commit_spot got saw_f=%0d saw_dp=%0d want 1 1", saw_f, saw_dp);
      end
   endtask
   task automatic test_last_wins();
      bit saw5 = 0, saw1 = 0;
      wait_pos(1);
      value = 16'h1234; load = 1; step();
      load = 0; step();
      value = 16'h5678; load = 1; step();
      load = 0;
      for (int i = 0; i < 48; i++) begin
         step();
         checks++;
         if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
            errors++; $display("FAIL last_wins cyc %0d %s", i, obs());
         end
         if (an == 4'b0111 && seg == font[5]) saw5 = 1;
         if (an == 4'b0111 && seg == font[1]) saw1 = 1;
      end
      checks++;
      if (!saw5 || saw1) begin
         errors++; $display("FAIL last_wins_spot got saw5=%0d saw1=%0d want 1 0", saw5, saw1);
      end
   endtask
   task automatic test_lz();
      logic [15:0] vals [2] = '{16'h0005, 16'h0000};
      blank_lz = 1; dp_in = 4'b1111;
      for (int v = 0; v < 2; v++) begin
         value = vals[v]; load = 1; step();
         load = 0;
         for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
               errors++; $display("FAIL lz val=%h cyc %0d %s", vals[v], i, obs());
            end
            if (i > 20 && an != 4'hF) begin
               checks++;
               if (an !== 4'b1110 || seg !== font[vals[v][3:0]]) begin
                  errors++; $display("FAIL lz_only_digit0 got an=%b seg=%b want 1110 %b", an, seg, font[vals[v][3:0]]);
               end
            end
         end
      end
   endtask
   task automatic test_coincide();
      logic [6:0] first_d0 = 7'h7F, last_d0 = 7'h7F;
      bit got_first = 0;
      blank_lz = 0; dp_in = 0;
      wait_pos(3);
      value = 16'h1111; load = 1; step();
      load = 0;
      wait_pos(15);
      value = 16'h2222; load = 1; step();
      load = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         checks++;
         if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
            errors++; $display("FAIL coincide cyc %0d %s", i, obs());
         end
         if (an == 4'b1110) begin
            if (!got_first) first_d0 = seg;
            got_first = 1;
            last_d0 = seg;
         end
      end
      checks++;
      if (first_d0 !== font[1] || last_d0 !== font[2]) begin
         errors++; $display("FAIL coincide_order got first=%b last=%b want %b %b", first_d0, last_d0, font[1], font[2]);
      end
   endtask
   task automatic test_enable();
      logic [3:0] first_an = 4'hF;
      wait_pos(9);
      enable = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0} ||
             {an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
            errors++; $display("FAIL disabled cyc %0d %s", i, obs());
         end
      end
      enable = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         checks++;
         if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
            errors++; $display("FAIL reenable cyc %0d %s", i, obs());
         end
         if (i == 0) first_an = an;
      end
      checks++;
      if (first_an !== 4'b1011) begin
         errors++; $display("FAIL resume_slot got an=%b want 1011", first_an);
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         enable   = ($urandom % 16) != 0;
         load     = ($urandom % 8) == 0;
         value    = 16'($urandom);
         dp_in    = 4'($urandom);
         blank_lz = ($urandom % 2) == 1;
         step();
         checks++;
         if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
            errors++; $display("FAIL random cyc %0d %s", i, obs());
         end
      end
      enable = 1; load = 0; blank_lz = 0;
   endtask
   task automatic test_rst_mid();
      wait_pos(2);
      value = 16'hABCD; dp_in = 4'hF; load = 1; step();
      load = 0;
      wait_pos(6);
      rst = 1; step();
      checks++;
      if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++; $display("FAIL rst_mid got an=%b seg=%b dp=%b fs=%b want 1111 1111111 1 0", an, seg, dp, frame_start);
      end
      rst = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         checks++;
         if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
            errors++; $display("FAIL after_rst cyc %0d %s", i, obs());
         end
      end
   endtask
   initial begin
      test_reset();
      test_load_commit();
      test_last_wins();
      test_lz();
      test_coincide();
      test_enable();
      test_random();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
